// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and constants for the UART program loader
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs little-endian bytes into 32-bit words and keeps a running XOR
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [1:0]  idx,
    output logic [31:0] word,
    output logic        word_done,
    output logic [7:0]  xor_sum
);

    logic [23:0] lanes;

    // Collect bytes 0..2 into lanes; byte 3 completes the word and raises a one-cycle done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lanes     <= '0;
            idx       <= '0;
            word      <= '0;
            word_done <= 1'b0;
            xor_sum   <= '0;
        end else begin
            word_done <= en && !clr && idx == 2'd3;
            if (clr) begin
                lanes   <= '0;
                idx     <= '0;
                xor_sum <= '0;
            end else if (en) begin
                idx     <= idx + 2'd1;
                xor_sum <= xor_sum ^ data;
                case (idx)
                    2'd0:    lanes[7:0]   <= data;
                    2'd1:    lanes[15:8]  <= data;
                    2'd2:    lanes[23:16] <= data;
                    default: word         <= {data, lanes};
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_loader.sv
// uart_loader: receives a framed program image over UART, writes it to RAM, then releases the core
module uart_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxdata,
    input  logic        rxready,
    output logic        rxclk,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        busy,
    output logic        cpu_run,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    loader_state_t state, next_state;
    logic [7:0]  len_lo;
    logic [15:0] word_count;
    logic [15:0] count;
    logic [1:0]  idx;
    logic [7:0]  xor_sum;
    logic        accept;
    logic        data_en;
    logic        word_last_byte;

    // A byte is taken only when the previous pop strobe is low, which spaces acceptances two cycles apart
    assign accept         = rxready && !rxclk && state != DONE && state != ERROR;
    assign data_en        = accept && state == DATA;
    assign word_last_byte = data_en && idx == 2'd3;
    assign count          = {rxdata, len_lo};
    assign busy           = state == LEN_LO || state == LEN_HI || state == DATA || state == CHECK;
    assign cpu_run        = state == DONE;
    assign load_error     = state == ERROR;

    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept && state == IDLE),
        .en        (data_en),
        .data      (rxdata),
        .idx       (idx),
        .word      (mem_wdata),
        .word_done (mem_we),
        .xor_sum   (xor_sum)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Frame parsing: advance only on accepted bytes; DONE and ERROR never accept, so they are terminal
    always_comb begin
        next_state = state;
        if (accept) begin
            case (state)
                IDLE:    next_state = rxdata == SYNC_BYTE ? LEN_LO : IDLE;
                LEN_LO:  next_state = LEN_HI;
                LEN_HI:  next_state = {1'b0, count} > MAX_W ? ERROR : count == 16'd0 ? CHECK : DATA;
                DATA:    next_state = word_last_byte && words_loaded + 16'd1 == word_count ? CHECK : DATA;
                CHECK:   next_state = rxdata == xor_sum ? DONE : ERROR;
                default: next_state = state;
            endcase
        end
    end

    // Pop strobe, length capture, and write address/count set up alongside the assembler's write pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxclk        <= 1'b0;
            len_lo       <= '0;
            word_count   <= '0;
            words_loaded <= '0;
            mem_addr     <= BASE_ADDR;
        end else begin
            rxclk <= accept;
            if (accept && state == LEN_LO) len_lo <= rxdata;
            if (accept && state == LEN_HI) word_count <= count;
            if (word_last_byte) begin
                mem_addr     <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                words_loaded <= words_loaded + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed frames against uart_loader with hand-computed expectations
module tb_uart_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rxdata = 8'h00;
    logic        rxready = 1'b0;
    logic        rxclk;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        cpu_run;
    logic        load_error;
    logic [15:0] words_loaded;

    int n_cmp = 0;
    int n_err = 0;
    int pops  = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    uart_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rxdata       (rxdata),
        .rxready      (rxready),
        .rxclk        (rxclk),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .busy         (busy),
        .cpu_run      (cpu_run),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rxclk) pops <= pops + 1;
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rxdata  = b;
        rxready = 1'b1;
        @(negedge clk);
        rxready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] last);
        logic [7:0] f[12];
        f = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        f[11] = last;
        for (int i = 0; i < 12; i++) send_byte(f[i]);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        pops = 0;
    endtask

    task automatic chk_two_writes(input string tag);
        chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk({tag, "_a0"}, wr_addr[0], 32'h0000_0000);
            chk({tag, "_d0"}, wr_data[0], 32'h1234_5678);
            chk({tag, "_a1"}, wr_addr[1], 32'h0000_0004);
            chk({tag, "_d1"}, wr_data[1], 32'hDEAD_BEEF);
        end
    endtask

    initial begin
        int p;
        repeat (3) @(negedge clk);
        chk("rst_rxclk", rxclk, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_run", cpu_run, 1'b0);
        chk("rst_err", load_error, 1'b0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        rst = 1'b1;

        // Two-word load
        send_byte(8'hA5);
        chk("sync_busy", busy, 1'b1);
        chk("sync_pop", rxclk, 1'b1);
        for (int i = 0; i < 11; i++) send_byte(i == 0 ? 8'h02 : i == 1 ? 8'h00 : i == 2 ? 8'h78 : i == 3 ? 8'h56 :
                                              i == 4 ? 8'h34 : i == 5 ? 8'h12 : i == 6 ? 8'hEF : i == 7 ? 8'hBE :
                                              i == 8 ? 8'hAD : i == 9 ? 8'hDE : 8'h2A);
        repeat (3) @(negedge clk);
        chk_two_writes("ok");
        chk("ok_words", 32'(words_loaded), 32'd2);
        chk("ok_run", cpu_run, 1'b1);
        chk("ok_err", load_error, 1'b0);
        chk("ok_busy", busy, 1'b0);
        chk("ok_pops", 32'(pops), 32'd12);

        // Bad checksum
        do_reset();
        send_frame(8'h00);
        chk_two_writes("bad");
        chk("bad_err", load_error, 1'b1);
        chk("bad_run", cpu_run, 1'b0);
        p = pops;
        send_byte(8'hA5);
        send_byte(8'h11);
        repeat (2) @(negedge clk);
        chk("bad_nopop", 32'(pops), 32'(p));
        chk("bad_err_sticky", load_error, 1'b1);

        // Zero length
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        chk("zero_nwr", 32'(wr_addr.size()), 32'd0);
        chk("zero_run", cpu_run, 1'b1);
        chk("zero_words", 32'(words_loaded), 32'd0);

        // Oversize count with MAX_WORDS=4
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(8'h00);
        chk("over_err", load_error, 1'b1);
        chk("over_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("over_nwr", 32'(wr_addr.size()), 32'd0);
        chk("over_run", cpu_run, 1'b0);

        // Garbage before sync
        do_reset();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        chk("garb_busy", busy, 1'b0);
        send_frame(8'h2A);
        chk_two_writes("garb");
        chk("garb_pops", 32'(pops), 32'd15);
        chk("garb_words", 32'(words_loaded), 32'd2);
        chk("garb_run", cpu_run, 1'b1);

        // Reset mid-load
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        repeat (2) @(negedge clk);
        chk("mid_nwr", 32'(wr_addr.size()), 32'd1);
        chk("mid_words", 32'(words_loaded), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_words", 32'(words_loaded), 32'd0);
        chk("mid_rst_wdata", mem_wdata, 32'h0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_addr", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        send_frame(8'h2A);
        chk_two_writes("reload");
        chk("reload_words", 32'(words_loaded), 32'd2);
        chk("reload_run", cpu_run, 1'b1);
        chk("reload_err", load_error, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
